// File: rtl/spi_pkg.sv
// Shared types and default widths for the mode-0 SPI slave frame controller.
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_READ_WAIT,
    ST_READ_SHIFT,
    ST_WRITE_SHIFT,
    ST_WRITE_COMMIT,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Conditioned SPI pin events plus the external memory port of the SPI slave controller.
interface spi_slave_ctrl_if
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cs_n;
  logic              sclk_posedge;
  logic              sclk_negedge;
  logic              mosi;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              miso;
  logic              miso_oe;

  modport slave (
    input  cs_n, sclk_posedge, sclk_negedge, mosi, mem_rdata,
    output mem_addr, mem_wdata, mem_we, miso, miso_oe
  );

  modport master (
    output cs_n, sclk_posedge, sclk_negedge, mosi, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, miso, miso_oe
  );

endinterface

// File: rtl/spi_shiftreg.sv
// SPI data shift register: parallel load, shift-in on SCLK rise, shift-out on SCLK fall, MSB out.
module spi_shiftreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_in,
  input  logic              shift_out,
  input  logic              serial_in,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] q,
  output logic              msb
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_in) begin
      q <= {q[DATA_W-2:0], serial_in};
    end else if (shift_out) begin
      q <= {q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = q[DATA_W-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// Mode-0 SPI slave frame controller: command capture, read/write sequencing, single-cycle memory access.
// Define SPI_AUTOINC_EN to turn the post-byte DONE state into an address-incrementing burst.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic             clk,
  input logic             reset,
  spi_slave_ctrl_if.slave bus
);

  spi_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              mem_we_q;
  logic              miso_oe_q;
  logic [DATA_W-1:0] sr_q;
  logic              sr_msb;
  logic              sr_load;
  logic              sr_shift_in;
  logic              sr_shift_out;

  // A deasserted CS swallows any coincident SCLK pulse; a rise beats a simultaneous fall.
  logic pos_ev;
  logic neg_ev;
  logic last_bit;

  assign pos_ev   = bus.sclk_posedge & ~bus.cs_n;
  assign neg_ev   = bus.sclk_negedge & ~bus.sclk_posedge & ~bus.cs_n;
  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sr_load      = 1'b0;
    sr_shift_in  = 1'b0;
    sr_shift_out = 1'b0;
    case (state)
      ST_GET_CMD, ST_WRITE_SHIFT: sr_shift_in  = pos_ev;
      ST_READ_WAIT:               sr_load      = neg_ev;
      ST_READ_SHIFT:              sr_shift_out = neg_ev;
      default: ;
    endcase
  end

  spi_shiftreg #(.DATA_W(DATA_W)) u_sr (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .shift_in  (sr_shift_in),
    .shift_out (sr_shift_out),
    .serial_in (bus.mosi),
    .load_data (bus.mem_rdata),
    .q         (sr_q),
    .msb       (sr_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr      <= '0;
      mem_we_q  <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (bus.cs_n) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_GET_CMD;
          end
          ST_GET_CMD: begin
            if (pos_ev) begin
              if (last_bit) begin
                // The address is the seven bits already shifted in; live mosi is the R/W flag.
                addr  <= sr_q[DATA_W-2:0];
                cnt   <= '0;
                state <= (bus.mosi == RW_READ) ? ST_READ_WAIT : ST_WRITE_SHIFT;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_READ_WAIT: begin
            if (neg_ev) begin
              miso_oe_q <= 1'b1;
              state     <= ST_READ_SHIFT;
            end
          end
          ST_READ_SHIFT: begin
            if (pos_ev) begin
              if (last_bit) begin
                miso_oe_q <= 1'b0;
                cnt       <= '0;
`ifdef SPI_AUTOINC_EN
                addr      <= addr + ADDR_W'(1);
                state     <= ST_READ_WAIT;
`else
                state     <= ST_DONE;
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_WRITE_SHIFT: begin
            if (pos_ev) begin
              if (last_bit) begin
                cnt      <= '0;
                mem_we_q <= 1'b1;
                state    <= ST_WRITE_COMMIT;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_WRITE_COMMIT: begin
`ifdef SPI_AUTOINC_EN
            addr  <= addr + ADDR_W'(1);
            cnt   <= '0;
            state <= ST_WRITE_SHIFT;
`else
            state <= ST_DONE;
`endif
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = sr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.miso      = sr_msb;
  assign bus.miso_oe   = miso_oe_q;

endmodule
